// File: rtl/sv_fetch_sequencer_if.sv
// Bundles the sequencer's control, SV RAM read port and pixel stream.
// master is the sequencer side; slave is the RAM/consumer side.
interface sv_fetch_sequencer_if #(
    parameter int XLEN_PIXEL = 8,
    parameter int NUM_SV     = 2,
    parameter int ADDR_WIDTH = 10
);
    localparam int SV_IDX_W = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;

    logic                  start;
    logic                  stall_MEM;
    logic [XLEN_PIXEL-1:0] ram_do;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [XLEN_PIXEL-1:0] pix_out;
    logic                  pix_valid;
    logic [SV_IDX_W-1:0]   sv_idx;
    logic                  sv_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, stall_MEM, ram_do,
        output ram_re, ram_addr, pix_out, pix_valid, sv_idx, sv_last, busy, done
    );

    modport slave (
        output start, stall_MEM, ram_do,
        input  ram_re, ram_addr, pix_out, pix_valid, sv_idx, sv_last, busy, done
    );
endinterface

// File: rtl/sv_fetch_sequencer.sv
// Walks the SV block RAM once per start request, streaming every pixel of
// every support vector in ascending address order with its vector tags.
module sv_fetch_sequencer #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 4,
    parameter int NUM_SV        = 2,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    sv_fetch_sequencer_if.master bus
);
    localparam int PIX_W = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam int SV_W  = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;

    generate
        if (NUM_SV * NUM_OF_PIXELS > 2 ** ADDR_WIDTH) begin : g_addr_check
            $error("sv_fetch_sequencer: SV RAM does not fit in ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PIX_W-1:0]    pix_cnt;
    logic [PIX_W-1:0]    pix_cnt_nxt;
    logic [SV_W-1:0]     sv_cnt;
    logic [SV_W-1:0]     sv_cnt_nxt;
    logic                pix_end;
    logic                sv_end;
    logic                read_en;
    logic [XLEN_PIXEL-1:0] pix_data;

    assign pix_end = (pix_cnt == PIX_W'(NUM_OF_PIXELS - 1));
    assign sv_end  = (sv_cnt == SV_W'(NUM_SV - 1));
    assign read_en = (state == FETCH) && !bus.stall_MEM;

    // Pixel data is passed straight through; pix_valid qualifies it.
    assign pix_data    = bus.ram_do;
    assign bus.pix_out = pix_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            sv_cnt        <= '0;
            bus.pix_valid <= 1'b0;
            bus.sv_idx    <= '0;
            bus.sv_last   <= 1'b0;
        end else begin
            state         <= state_nxt;
            pix_cnt       <= pix_cnt_nxt;
            sv_cnt        <= sv_cnt_nxt;
            bus.pix_valid <= read_en;
            bus.sv_idx    <= sv_cnt;
            bus.sv_last   <= read_en && pix_end;
        end
    end

    always_comb begin
        state_nxt   = state;
        pix_cnt_nxt = pix_cnt;
        sv_cnt_nxt  = sv_cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt   = FETCH;
                    pix_cnt_nxt = '0;
                    sv_cnt_nxt  = '0;
                end
            end
            FETCH: begin
                if (read_en) begin
                    if (pix_end) begin
                        pix_cnt_nxt = '0;
                        // Wrap the SV counter on the final read so IDLE sees zeros.
                        if (sv_end) begin
                            sv_cnt_nxt = '0;
                            state_nxt  = DRAIN;
                        end else begin
                            sv_cnt_nxt = sv_cnt + SV_W'(1);
                        end
                    end else begin
                        pix_cnt_nxt = pix_cnt + PIX_W'(1);
                    end
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_re   = read_en;
        bus.ram_addr = '0;
        bus.busy     = (state != IDLE);
        bus.done     = (state == DONE);
        if (state == FETCH) begin
            bus.ram_addr = ADDR_WIDTH'(sv_cnt) * ADDR_WIDTH'(NUM_OF_PIXELS)
                         + ADDR_WIDTH'(pix_cnt);
        end
    end
endmodule

// File: tb/tb_sv_fetch_sequencer.sv
// Self-checking bench: directed scenarios plus random start/stall/reset traffic
// compared against a read-count based reference model.
module tb_sv_fetch_sequencer;
    localparam int XLEN  = 8;
    localparam int NPIX  = 4;
    localparam int NSV   = 2;
    localparam int AW    = 10;
    localparam int TOTAL = NPIX * NSV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sv_fetch_sequencer_if #(.XLEN_PIXEL(XLEN), .NUM_SV(NSV), .ADDR_WIDTH(AW)) bus();

    sv_fetch_sequencer #(
        .XLEN_PIXEL(XLEN),
        .NUM_OF_PIXELS(NPIX),
        .NUM_SV(NSV),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // RAM returns address + 0x10 one cycle after the read.
    logic [XLEN-1:0] ram_data = '0;
    assign bus.ram_do = ram_data;
    always @(posedge clk) if (bus.ram_re) ram_data <= XLEN'(bus.ram_addr + AW'(16));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a pass is "active" with a count of reads issued; after
    // the last read come one drain cycle and one done cycle.
    bit m_active = 0;
    int m_reads  = 0;
    int m_post   = 0;
    bit m_pv     = 0;
    int m_paddr  = 0;
    int pulses   = 0;
    int cyc      = 0;
    int done_cyc = -1;
    int done_cnt = 0;

    task automatic step(input bit st, input bit stl);
        bit exp_re;
        bit exp_done;
        @(negedge clk);
        bus.start     = st;
        bus.stall_MEM = stl;
        #1;
        exp_re   = m_active && (m_reads < TOTAL) && !stl;
        exp_done = m_active && (m_reads == TOTAL) && (m_post == 1);
        check_eq("ram_re", 32'(bus.ram_re), 32'(exp_re));
        check_eq("ram_addr", 32'(bus.ram_addr), (m_active && m_reads < TOTAL) ? m_reads : 0);
        check_eq("busy", 32'(bus.busy), 32'(m_active));
        check_eq("done", 32'(bus.done), 32'(exp_done));
        check_eq("pix_valid", 32'(bus.pix_valid), 32'(m_pv));
        if (m_pv) begin
            check_eq("pix_out", 32'(bus.pix_out), (m_paddr + 16) & 32'hFF);
            check_eq("sv_idx", 32'(bus.sv_idx), m_paddr / NPIX);
            check_eq("sv_last", 32'(bus.sv_last), 32'((m_paddr % NPIX) == NPIX - 1));
        end else begin
            check_eq("sv_last_idle", 32'(bus.sv_last), 0);
        end
        if (bus.pix_valid) pulses++;
        if (bus.done) begin
            done_cyc = cyc;
            done_cnt++;
        end
        if (exp_done) check_eq("pulses", pulses, TOTAL);
        @(posedge clk);
        cyc++;
        m_pv = exp_re;
        if (exp_re) m_paddr = m_reads;
        if (!m_active) begin
            if (st) begin
                m_active = 1;
                m_reads  = 0;
                m_post   = 0;
                pulses   = 0;
            end
        end else if (m_reads < TOTAL) begin
            if (exp_re) m_reads++;
        end else if (m_post == 1) begin
            m_active = 0;
        end else begin
            m_post++;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        bus.start     = 1'b0;
        bus.stall_MEM = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_ram_re", 32'(bus.ram_re), 0);
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 0);
        check_eq("rst_pix_valid", 32'(bus.pix_valid), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_sv_idx", 32'(bus.sv_idx), 0);
        check_eq("rst_sv_last", 32'(bus.sv_last), 0);
        #1 rst = 1'b0;
        m_active = 0;
        m_pv     = 0;
    endtask

    int dc0;

    initial begin
        bus.start     = 1'b0;
        bus.stall_MEM = 1'b0;
        #1;
        check_eq("reset_busy", 32'(bus.busy), 0);
        check_eq("reset_ram_re", 32'(bus.ram_re), 0);
        check_eq("reset_ram_addr", 32'(bus.ram_addr), 0);
        check_eq("reset_pix_valid", 32'(bus.pix_valid), 0);
        check_eq("reset_done", 32'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Unstalled pass, then a back-to-back pass started in cycle 11.
        cyc = 0;
        for (int i = 0; i <= 10; i++) step(i == 0, 1'b0);
        check_eq("done_cycle_plain", done_cyc, 10);
        for (int i = 11; i <= 22; i++) step(i == 11, 1'b0);
        check_eq("done_cycle_b2b", done_cyc, 21);

        // Stall in cycles 3-4.
        cyc = 0;
        for (int i = 0; i <= 13; i++) step(i == 0, (i == 3) || (i == 4));
        check_eq("done_cycle_stall", done_cyc, 12);

        // Extra start pulses mid-pass and in DONE are dropped.
        cyc = 0;
        dc0 = done_cnt;
        for (int i = 0; i <= 14; i++) step((i == 0) || (i == 3) || (i == 10), 1'b0);
        check_eq("done_cycle_ignored", done_cyc, 10);
        check_eq("single_done", done_cnt - dc0, 1);

        // Asynchronous reset in cycle 5 aborts without done; restart from 0.
        cyc = 0;
        dc0 = done_cnt;
        for (int i = 0; i <= 4; i++) step(i == 0, 1'b0);
        mid_reset();
        check_eq("abort_no_done", done_cnt - dc0, 0);
        step(1'b1, 1'b0);
        check_eq("restart_addr", 32'(bus.ram_addr), 0);
        for (int i = 0; i <= 11; i++) step(1'b0, 1'b0);
        check_eq("restart_done", done_cnt - dc0, 1);

        // Random start/stall traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) mid_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
        check_eq("final_idle", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sv_fetch_sequencer.md
SV_FETCH_SEQUENCER -- requirements
Module: sv_fetch_sequencer

Interface
REQ-001 Parameter XLEN_PIXEL, default 8: pixel/data width in bits.
REQ-002 Parameter NUM_OF_PIXELS, default 4: pixels per support vector.
REQ-003 Parameter NUM_SV, default 2: support vectors per classification pass.
REQ-004 Parameter ADDR_WIDTH, default 10: SV RAM address width; NUM_SV*NUM_OF_PIXELS SHALL be <= 2^ADDR_WIDTH.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin a fetch pass.
REQ-008 stall_MEM  input  1  memory stall; while high no new RAM read is issued.
REQ-009 ram_do  input  XLEN_PIXEL  SV block RAM read data, valid one cycle after the read was issued.
REQ-010 ram_re  output  1  SV block RAM read enable.
REQ-011 ram_addr  output  ADDR_WIDTH  SV block RAM read address.
REQ-012 pix_out  output  XLEN_PIXEL  fetched pixel, equal to ram_do.
REQ-013 pix_valid  output  1  pix_out holds a fetched pixel this cycle.
REQ-014 sv_idx  output  clog2(NUM_SV) (min 1)  support-vector index of pix_out.
REQ-015 sv_last  output  1  pix_out is the last pixel (index NUM_OF_PIXELS-1) of its vector.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on pass completion.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, DRAIN, DONE; state, counters and pix_valid/sv_idx/sv_last are registers.
REQ-019 IDLE: start=1 -> FETCH next cycle with pixel counter=0, SV counter=0; start=0 -> stay.
REQ-020 start SHALL be ignored in FETCH, DRAIN and DONE.
REQ-021 ram_re SHALL equal (state==FETCH) && !stall_MEM, combinationally.
REQ-022 ram_addr SHALL equal sv_cnt*NUM_OF_PIXELS + pix_cnt, truncated to ADDR_WIDTH; 0 outside FETCH.
REQ-023 Each cycle with ram_re=1: pix_cnt increments; at NUM_OF_PIXELS-1 it wraps to 0 and sv_cnt increments.
REQ-024 ram_re=1 on the final address (sv_cnt=NUM_SV-1, pix_cnt=NUM_OF_PIXELS-1) -> DRAIN next cycle.
REQ-025 stall_MEM=1 in FETCH SHALL freeze pix_cnt, sv_cnt and state; a read issued the previous cycle still completes.
REQ-026 pix_valid SHALL be ram_re delayed one cycle; sv_idx/sv_last SHALL be the counters of that read delayed one cycle.
REQ-027 pix_out SHALL pass ram_do combinationally; its value is meaningful only when pix_valid=1.
REQ-028 DRAIN lasts exactly one cycle (last pixel presented), then DONE; stall_MEM has no effect in DRAIN.
REQ-029 DONE lasts exactly one cycle with done=1, then IDLE; a start in DONE is dropped.
REQ-030 Exactly NUM_SV*NUM_OF_PIXELS pix_valid pulses per pass, addresses strictly ascending from 0, none repeated or skipped.
REQ-031 Unstalled latency: start sampled at edge k -> first ram_re cycle k+1, first pix_valid k+2, done at k+NUM_SV*NUM_OF_PIXELS+2.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, counters 0, pix_valid=0, sv_idx=0, sv_last=0, done=0; hence ram_re=0, ram_addr=0, busy=0.
REQ-033 rst asserted mid-pass SHALL abort it without a done pulse; the next start begins again at address 0.

Verification (defaults: 4 pixels, 2 SVs)
REQ-034 Unstalled pass, start at edge 0 -> ram_addr 0..7 with ram_re=1 in cycles 1-8, pix_valid cycles 2-9, sv_idx 0,0,0,0,1,1,1,1, sv_last high cycles 5 and 9, done high cycle 10 only, busy cycles 1-10.
REQ-035 stall_MEM=1 for cycles 3-4 -> ram_re=0 in cycles 3-4, ram_addr holds 2, pix_valid=0 in cycles 4-5, pass completes with done at cycle 12 and all 8 addresses read once.
REQ-036 Second start pulse at cycles 3 and 10 -> both ignored, single done pulse, no second pass.
REQ-037 rst asserted asynchronously mid-cycle 5 -> outputs cleared before next edge, no done; new start reads address 0 first.
REQ-038 ram_do model returning address+0x10 -> pix_out sequence 0x10..0x17 when pix_valid=1.
REQ-039 Back-to-back passes: start in cycle 11 (IDLE) -> second pass identical to REQ-034 shifted by 11 cycles.
